// File: rtl/imem_stream_prefetch_if.sv
// imem_stream_prefetch_if: icache-side and memory-side handshake bundle for the stream prefetcher.
interface imem_stream_prefetch_if #(parameter int WORD_W = 32) ();
  logic              mem_req_valid;
  logic [31:0]       mem_req_addr;
  logic              mem_req_ready;
  logic [WORD_W-1:0] mem_req_rdata;
  logic              mm_req_valid;
  logic              mm_req_ready;
  logic [31:0]       mm_req_addr;
  logic              mm_resp_valid;
  logic [WORD_W-1:0] mm_resp_data;
  modport slave (
    input  mem_req_valid, mem_req_addr, mm_req_ready, mm_resp_valid, mm_resp_data,
    output mem_req_ready, mem_req_rdata, mm_req_valid, mm_req_addr
  );
  modport master (
    output mem_req_valid, mem_req_addr, mm_req_ready, mm_resp_valid, mm_resp_data,
    input  mem_req_ready, mem_req_rdata, mm_req_valid, mm_req_addr
  );
endinterface

// File: rtl/imem_stream_prefetch.sv
// imem_stream_prefetch: icache refill front-end with a one-line sequential stream buffer.
module imem_stream_prefetch #(
  parameter int BLOCK_SIZE  = 4,
  parameter int NUM_BLOCKS  = 4,
  parameter int PREFETCH_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_stream_prefetch_if.slave bus,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
);
  localparam int WORD_W = 8 * BLOCK_SIZE;
  localparam int OFF    = $clog2(NUM_BLOCKS);
  localparam int TW     = 30 - OFF;
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DEM_ISS  = 3'd1;
  localparam logic [2:0] DEM_WAIT = 3'd2;
  localparam logic [2:0] RESP     = 3'd3;
  localparam logic [2:0] PF_ISS   = 3'd4;
  localparam logic [2:0] PF_WAIT  = 3'd5;
  logic [2:0]        r_state;
  logic              r_seen, r_pend, r_rdy, r_mm_valid;
  logic [31:2]       r_addr;
  logic [31:0]       r_mm_addr, r_hits, r_misses;
  logic [WORD_W-1:0] r_rdata;
  logic [WORD_W-1:0] r_buf [NUM_BLOCKS];
  logic [TW-1:0]     r_pf_tag, r_pf_itag;
  logic [NUM_BLOCKS-1:0] r_pf_vld;
  logic [OFF-1:0]    r_pf_word, w_pf_word;
  logic              w_acc, w_dem, w_hit, w_pf_need, w_unused;
  logic [31:2]       w_daddr;
  logic [TW-1:0]     w_dline, w_rline, w_rline_nx;
  logic [OFF-1:0]    w_dword, w_rword;
  assign w_acc      = bus.mem_req_valid && !r_seen;
  assign w_dem      = w_acc || r_pend;
  assign w_daddr    = w_acc ? bus.mem_req_addr[31:2] : r_addr;
  assign w_dline    = w_daddr[31:OFF+2];
  assign w_dword    = w_daddr[OFF+1:2];
  assign w_hit      = w_dline == r_pf_tag && r_pf_vld[w_dword];
  assign w_rline    = r_addr[31:OFF+2];
  assign w_rword    = r_addr[OFF+1:2];
  assign w_rline_nx = w_rline + TW'(1);
  assign w_pf_need  = (PREFETCH_EN != 0) && !(&r_pf_vld);
  assign w_unused   = ^bus.mem_req_addr[1:0];
  always_comb begin
    w_pf_word = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) w_pf_word = r_pf_vld[i] ? w_pf_word : OFF'(i);
  end
  assign bus.mem_req_ready = r_rdy;
  assign bus.mem_req_rdata = r_rdata;
  assign bus.mm_req_valid  = r_mm_valid;
  assign bus.mm_req_addr   = r_mm_addr;
  assign stat_hits         = r_hits;
  assign stat_misses       = r_misses;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_seen     <= 1'b0;
      r_pend     <= 1'b0;
      r_addr     <= '0;
      r_rdy      <= 1'b0;
      r_rdata    <= '0;
      r_mm_valid <= 1'b0;
      r_mm_addr  <= '0;
      r_hits     <= '0;
      r_misses   <= '0;
      r_pf_tag   <= '0;
      r_pf_itag  <= '0;
      r_pf_vld   <= '0;
      r_pf_word  <= '0;
    end else begin
      r_seen <= bus.mem_req_valid;
      r_pend <= (r_pend || w_acc) && r_state != IDLE;
      r_addr <= w_acc ? bus.mem_req_addr[31:2] : r_addr;
      r_rdy  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_dem && w_hit) begin
            r_state <= RESP;
            r_rdy   <= 1'b1;
            r_rdata <= r_buf[w_dword];
            r_hits  <= (r_hits == '1) ? r_hits : r_hits + 32'd1;
            if (&w_dword) begin
              r_pf_tag <= r_pf_tag + TW'(1);
              r_pf_vld <= '0;
            end
          end else if (w_dem) begin
            r_state    <= DEM_ISS;
            r_mm_valid <= 1'b1;
            r_mm_addr  <= {w_daddr, 2'b00};
            r_misses   <= (r_misses == '1) ? r_misses : r_misses + 32'd1;
          end else if (w_pf_need) begin
            r_state    <= PF_ISS;
            r_mm_valid <= 1'b1;
            r_mm_addr  <= {r_pf_tag, w_pf_word, 2'b00};
            r_pf_itag  <= r_pf_tag;
            r_pf_word  <= w_pf_word;
          end
        end
        DEM_ISS: if (bus.mm_req_ready) begin
          r_mm_valid <= 1'b0;
          r_state    <= DEM_WAIT;
        end
        DEM_WAIT: if (bus.mm_resp_valid) begin
          r_state <= RESP;
          r_rdy   <= 1'b1;
          r_rdata <= bus.mm_resp_data;
          if (w_rline == r_pf_tag) begin
            r_buf[w_rword]    <= bus.mm_resp_data;
            r_pf_vld[w_rword] <= 1'b1;
          end else if (w_rline_nx != r_pf_tag) begin
            r_pf_tag <= w_rline_nx;
            r_pf_vld <= '0;
          end
        end
        RESP: r_state <= IDLE;
        PF_ISS: if (bus.mm_req_ready) begin
          r_mm_valid <= 1'b0;
          r_state    <= PF_WAIT;
        end
        // a fill whose line was retargeted away while in flight is dropped
        PF_WAIT: if (bus.mm_resp_valid) begin
          r_state <= IDLE;
          if (r_pf_itag == r_pf_tag) begin
            r_buf[r_pf_word]    <= bus.mm_resp_data;
            r_pf_vld[r_pf_word] <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_stream_prefetch.sv
// tb_imem_stream_prefetch: directed checks of the stream prefetcher against a 3-cycle memory model.
module tb_imem_stream_prefetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [31:0] h1, m1, h2, m2;
  imem_stream_prefetch_if #(.WORD_W(32)) b1 ();
  imem_stream_prefetch_if #(.WORD_W(32)) b2 ();
  imem_stream_prefetch #(.BLOCK_SIZE(4), .NUM_BLOCKS(4), .PREFETCH_EN(1)) u1 (
    .clk(clk), .reset(reset), .bus(b1.slave), .stat_hits(h1), .stat_misses(m1));
  imem_stream_prefetch #(.BLOCK_SIZE(4), .NUM_BLOCKS(4), .PREFETCH_EN(0)) u2 (
    .clk(clk), .reset(reset), .bus(b2.slave), .stat_hits(h2), .stat_misses(m2));
  logic [1:0]  c1 = 2'd0, c2 = 2'd0;
  logic [31:0] a1 = '0, a2 = '0;
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  assign b1.mm_req_ready  = c1 == 2'd0;
  assign b1.mm_resp_valid = v1;
  assign b1.mm_resp_data  = a1 ^ 32'hA5A5A5A5;
  assign b2.mm_req_ready  = c2 == 2'd0;
  assign b2.mm_resp_valid = v2;
  assign b2.mm_resp_data  = a2 ^ 32'hA5A5A5A5;
  always @(posedge clk) begin
    v1 <= c1 == 2'd1;
    if (c1 != 2'd0) c1 <= c1 - 2'd1;
    else if (b1.mm_req_valid) begin c1 <= 2'd3; a1 <= b1.mm_req_addr; q1.push_back(b1.mm_req_addr); end
  end
  always @(posedge clk) begin
    v2 <= c2 == 2'd1;
    if (c2 != 2'd0) c2 <= c2 - 2'd1;
    else if (b2.mm_req_valid) begin c2 <= 2'd3; a2 <= b2.mm_req_addr; q2.push_back(b2.mm_req_addr); end
  end
  task automatic rd(input bit s, input logic [31:0] a, output logic [31:0] d, output int lat);
    lat = 0;
    if (s) begin b2.mem_req_valid = 1'b1; b2.mem_req_addr = a; end
    else begin b1.mem_req_valid = 1'b1; b1.mem_req_addr = a; end
    do begin @(negedge clk); lat++; end while (!(s ? b2.mem_req_ready : b1.mem_req_ready) && lat < 200);
    d = s ? b2.mem_req_rdata : b1.mem_req_rdata;
    checks++;
    if ((s ? b2.mem_req_ready : b1.mem_req_ready) !== 1'b1) begin failures++; $display("FAIL rd_ready addr=%h got=0 exp=1", a); end
    if (s) b2.mem_req_valid = 1'b0; else b1.mem_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ((s ? b2.mem_req_ready : b1.mem_req_ready) !== 1'b0) begin failures++; $display("FAIL rd_single_pulse addr=%h got=1 exp=0", a); end
  endtask
  task automatic wait_log(input logic [31:0] a);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(q1.size() > 0 && q1[$] == a) && n < 200);
    checks++;
    if (!(q1.size() > 0 && q1[$] == a)) begin failures++; $display("FAIL wait_mm_req got=none exp=%h", a); end
  endtask
  task automatic test_reset();
    b1.mem_req_valid = 1'b0; b1.mem_req_addr = '0;
    b2.mem_req_valid = 1'b0; b2.mem_req_addr = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (b1.mem_req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", b1.mem_req_ready); end
    checks++; if (b1.mem_req_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", b1.mem_req_rdata); end
    checks++; if (b1.mm_req_valid !== 1'b0) begin failures++; $display("FAIL rst_mm_valid got=%b exp=0", b1.mm_req_valid); end
    checks++; if (b1.mm_req_addr !== 32'h0) begin failures++; $display("FAIL rst_mm_addr got=%h exp=0", b1.mm_req_addr); end
    checks++; if (h1 !== 32'h0 || m1 !== 32'h0) begin failures++; $display("FAIL rst_stats got=%h/%h exp=0/0", h1, m1); end
  endtask
  task automatic test_cold_miss();
    logic [31:0] d;
    int lat;
    reset = 1'b0;
    rd(1'b0, 32'h100, d, lat);
    checks++; if (d !== 32'hA5A5A4A5) begin failures++; $display("FAIL cold_data got=%h exp=a5a5a4a5", d); end
    checks++; if (lat != 6) begin failures++; $display("FAIL cold_latency got=%0d exp=6", lat); end
    checks++; if (m1 !== 32'd1 || h1 !== 32'd0) begin failures++; $display("FAIL cold_stats got=%0d/%0d exp=0/1", h1, m1); end
    checks++; if (q1.size() != 1 || q1[0] !== 32'h100) begin failures++; $display("FAIL cold_mm_req got_n=%0d exp_n=1 addr=100", q1.size()); end
    repeat (3) @(negedge clk);
    checks++; if (q1.size() != 2 || q1[q1.size()-1] !== 32'h110) begin failures++; $display("FAIL cold_first_pf got_n=%0d exp=110", q1.size()); end
  endtask
  task automatic test_seq_hits();
    logic [31:0] addrs [8] = '{32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C, 32'h0};
    logic [31:0] exps  [7] = '{32'hA5A5A4A1, 32'hA5A5A4AD, 32'hA5A5A4A9, 32'hA5A5A4B5, 32'hA5A5A4B1, 32'hA5A5A4BD, 32'hA5A5A4B9};
    logic [31:0] d;
    int lat, mark;
    mark = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin repeat (40) @(negedge clk); mark = q1.size(); end
      rd(1'b0, addrs[i], d, lat);
      checks++; if (d !== exps[i]) begin failures++; $display("FAIL seq_data addr=%h got=%h exp=%h", addrs[i], d, exps[i]); end
      if (i >= 3) begin
        checks++; if (lat != 1) begin failures++; $display("FAIL seq_hit_latency addr=%h got=%0d exp=1", addrs[i], lat); end
      end
    end
    checks++; if (h1 !== 32'd4 || m1 !== 32'd4) begin failures++; $display("FAIL seq_stats got=%0d/%0d exp=4/4", h1, m1); end
    repeat (10) @(negedge clk);
    checks++; if (q1.size() <= mark || q1[mark] !== 32'h120) begin failures++; $display("FAIL seq_retarget_pf got_n=%0d exp=120", q1.size() - mark); end
  endtask
  task automatic test_pf_merge();
    logic [31:0] d;
    int lat, mark, n114;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mark = q1.size();
    rd(1'b0, 32'h100, d, lat);
    wait_log(32'h114);
    rd(1'b0, 32'h114, d, lat);
    checks++; if (d !== 32'hA5A5A4B1) begin failures++; $display("FAIL merge_data got=%h exp=a5a5a4b1", d); end
    checks++; if (lat != 5) begin failures++; $display("FAIL merge_latency got=%0d exp=5", lat); end
    checks++; if (h1 !== 32'd1 || m1 !== 32'd1) begin failures++; $display("FAIL merge_stats got=%0d/%0d exp=1/1", h1, m1); end
    n114 = 0;
    for (int i = mark; i < q1.size(); i++) if (q1[i] == 32'h114) n114++;
    checks++; if (n114 != 1) begin failures++; $display("FAIL merge_mm_count got=%0d exp=1", n114); end
  endtask
  task automatic test_jump();
    logic [31:0] d;
    int lat, mark;
    wait_log(32'h118);
    mark = q1.size();
    rd(1'b0, 32'h4000, d, lat);
    checks++; if (d !== 32'hA5A5E5A5) begin failures++; $display("FAIL jump_data got=%h exp=a5a5e5a5", d); end
    checks++; if (lat != 10) begin failures++; $display("FAIL jump_latency got=%0d exp=10", lat); end
    checks++; if (m1 !== 32'd2) begin failures++; $display("FAIL jump_misses got=%0d exp=2", m1); end
    repeat (10) @(negedge clk);
    checks++; if (q1.size() < mark + 2 || q1[mark] !== 32'h4000 || q1[mark+1] !== 32'h4010) begin failures++; $display("FAIL jump_order got_n=%0d exp=4000,4010", q1.size() - mark); end
  endtask
  task automatic test_wrap();
    logic [31:0] d;
    int lat, mark;
    rd(1'b0, 32'hFFFFFFE0, d, lat);
    checks++; if (d !== 32'h5A5A5A45) begin failures++; $display("FAIL wrap_miss_data got=%h exp=5a5a5a45", d); end
    repeat (40) @(negedge clk);
    mark = q1.size();
    rd(1'b0, 32'hFFFFFFFC, d, lat);
    checks++; if (d !== 32'h5A5A5A59) begin failures++; $display("FAIL wrap_hit_data got=%h exp=5a5a5a59", d); end
    checks++; if (lat != 1) begin failures++; $display("FAIL wrap_hit_latency got=%0d exp=1", lat); end
    checks++; if (h1 !== 32'd2 || m1 !== 32'd3) begin failures++; $display("FAIL wrap_stats got=%0d/%0d exp=2/3", h1, m1); end
    repeat (10) @(negedge clk);
    checks++; if (q1.size() <= mark || q1[mark] !== 32'h0) begin failures++; $display("FAIL wrap_pf_addr got_n=%0d exp=0", q1.size() - mark); end
  endtask
  task automatic test_reset_mid();
    int pulses;
    b1.mem_req_valid = 1'b1; b1.mem_req_addr = 32'h200;
    wait_log(32'h200);
    reset = 1'b1;
    b1.mem_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (b1.mm_req_valid !== 1'b0 || b1.mm_req_addr !== 32'h0) begin failures++; $display("FAIL mid_rst_mm got=%b/%h exp=0/0", b1.mm_req_valid, b1.mm_req_addr); end
    checks++; if (b1.mem_req_ready !== 1'b0 || b1.mem_req_rdata !== 32'h0) begin failures++; $display("FAIL mid_rst_ready got=%b/%h exp=0/0", b1.mem_req_ready, b1.mem_req_rdata); end
    checks++; if (h1 !== 32'h0 || m1 !== 32'h0) begin failures++; $display("FAIL mid_rst_stats got=%0d/%0d exp=0/0", h1, m1); end
    reset = 1'b0;
    pulses = 0;
    repeat (12) begin @(negedge clk); if (b1.mem_req_ready === 1'b1) pulses++; end
    checks++; if (pulses != 0) begin failures++; $display("FAIL mid_rst_late_resp got=%0d exp=0", pulses); end
  endtask
  task automatic test_no_prefetch();
    logic [31:0] d;
    int lat;
    repeat (10) @(negedge clk);
    checks++; if (q2.size() != 0) begin failures++; $display("FAIL nopf_idle_req got=%0d exp=0", q2.size()); end
    rd(1'b1, 32'h300, d, lat);
    checks++; if (d !== 32'hA5A5A6A5 || lat != 6) begin failures++; $display("FAIL nopf_miss got=%h/%0d exp=a5a5a6a5/6", d, lat); end
    repeat (20) @(negedge clk);
    checks++; if (q2.size() != 1) begin failures++; $display("FAIL nopf_after_miss got=%0d exp=1", q2.size()); end
    rd(1'b1, 32'h304, d, lat);
    checks++; if (d !== 32'hA5A5A6A1) begin failures++; $display("FAIL nopf_data304 got=%h exp=a5a5a6a1", d); end
    rd(1'b1, 32'h310, d, lat);
    checks++; if (d !== 32'hA5A5A6B5) begin failures++; $display("FAIL nopf_fill310 got=%h exp=a5a5a6b5", d); end
    rd(1'b1, 32'h310, d, lat);
    checks++; if (d !== 32'hA5A5A6B5 || lat != 1) begin failures++; $display("FAIL nopf_hit310 got=%h/%0d exp=a5a5a6b5/1", d, lat); end
    checks++; if (h2 !== 32'd1 || m2 !== 32'd3 || q2.size() != 3) begin failures++; $display("FAIL nopf_stats got=%0d/%0d/%0d exp=1/3/3", h2, m2, q2.size()); end
  endtask
  initial begin
    test_reset();
    test_cold_miss();
    test_seq_hits();
    test_pf_merge();
    test_jump();
    test_wrap();
    test_reset_mid();
    test_no_prefetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
